food_placer: RTL
================

Name: food_placer

Overview:
- Consumer end of the food-position generator interface.
- Takes candidate coordinates from the generator and checks them against the snake-body occupancy map.
- Requests a new candidate (eaten pulse) until it finds a free cell, then publishes the food position to the display/snake logic.
- Detects when the snake head reaches the food; on that event it pulses grow, bumps the score and starts re-placement.

Parameters:
- COORD_W, 4, width of each x/y coordinate (16x16 board).
- MAX_RETRY, 9, extra candidates tried after the first occupied one, before a forced commit (equals the generator period).
- SCORE_W, 8, score counter width.

Ports:
- clk_out  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- head_x  input  COORD_W  snake head column.
- head_y  input  COORD_W  snake head row.
- head_valid  input  1  one-cycle pulse when the head has moved to head_x/head_y.
- cand_x  input  COORD_W  generator candidate column (generator dout1).
- cand_y  input  COORD_W  generator candidate row (generator dout2).
- eaten  output  1  one-cycle request to the generator to advance its candidate.
- occ_rd_en  output  1  occupancy read strobe.
- occ_rd_x  output  COORD_W  occupancy read column.
- occ_rd_y  output  COORD_W  occupancy read row.
- occ_rd_data  input  1  cell occupied by body; valid exactly 1 cycle after occ_rd_en.
- food_x  output  COORD_W  committed food column.
- food_y  output  COORD_W  committed food row.
- food_valid  output  1  food_x/food_y hold a placed food.
- grow  output  1  one-cycle pulse: snake ate, lengthen by one.
- score  output  SCORE_W  foods eaten, saturating.
- board_full  output  1  sticky: a forced commit onto an occupied cell has happened.

Behaviour:
- All outputs are registered. Reset values: eaten=0, occ_rd_en=0, occ_rd_x/y=0, food_x/y=0, food_valid=0, grow=0, score=0, board_full=0, retry=0, state=CHECK.
- FSM states: CHECK, RESP, ADVANCE, IDLE.
- CHECK:
  - Drive occ_rd_en=1 and occ_rd_x/y = cand_x/cand_y for one cycle.
  - Hold that candidate in an internal register for commit.
  - Next state is RESP.
- RESP: sample occ_rd_data.
  - 0 (free): food_x/y <= held candidate, food_valid <= 1, retry <= 0, go to IDLE.
  - 1 and retry < MAX_RETRY: retry++, go to ADVANCE.
  - 1 and retry == MAX_RETRY: commit anyway (food_valid <= 1), board_full <= 1, retry <= 0, go to IDLE.
- ADVANCE:
  - Drive eaten=1 for exactly one cycle, then go to CHECK.
  - The generator updates on that same edge, so cand_x/cand_y are stable in the following CHECK cycle.
- IDLE, when head_valid=1 and head == food:
  - grow=1 for one cycle.
  - score <= score+1, saturating at all-ones.
  - food_valid <= 0.
  - go to ADVANCE.
- IDLE otherwise: hold all state.
- head_valid outside IDLE is ignored: no food is valid, so no grow and no score change.
- Latency from head hit to food_valid=1 with a free first candidate is 4 cycles:
  - hit edge → ADVANCE → CHECK → RESP → commit.
  - Each occupied candidate adds 3 cycles.
- After reset, the first placement uses the generator's current candidate without an eaten pulse.
- eaten is never asserted in two consecutive cycles.
- occ_rd_en and eaten are never asserted together.
- Asserting rst_n low mid-operation immediately clears all of the above, including a pending grow.

Decomposition:
- Shared package holds:
  - COORD_W and SCORE_W constants.
  - State encoding localparams: CHECK=2'd0, RESP=2'd1, ADVANCE=2'd2, IDLE=2'd3.
  - Board dimension constant, 16.
- No sub-module is needed. The retry counter and saturating score live inline in the single module.

Test Plan:
- Reset release, candidate (11,2), occ_rd_data=0 → occ read at (11,2); food=(11,2), food_valid=1 on cycle 2 after release; eaten never pulses.
- Food (11,2); head_valid with head (11,2) → grow pulse, score 0→1, food_valid=0; one eaten pulse; next candidate (7,8) free → food=(7,8) 4 cycles after the hit.
- Head (11,3) next to food (11,2) with head_valid → no grow, score unchanged, food unchanged.
- Candidates (14,10) then (3,4); occupancy returns 1 then 0 → two occ reads, one eaten pulse between them; food=(3,4), board_full=0.
- Occupancy stuck at 1 → exactly MAX_RETRY=9 eaten pulses; forced commit of the 10th candidate; board_full=1 and stays set until reset.
- score preloaded to 255 via 255 hits → next hit still pulses grow, score stays 255; assert rst_n mid-ADVANCE → all outputs return to reset values.

Source files
------------

// File: rtl/food_placer_pkg.sv
// food_placer_pkg: shared constants and the FSM state type for the
// food placement block (16x16 board, 4-bit coordinates, 8-bit score).
package food_placer_pkg;

  localparam int COORD_W   = 4;
  localparam int SCORE_W   = 8;
  localparam int BOARD_DIM = 16;

  // Placement FSM encoding.
  typedef enum logic [1:0] {
    CHECK   = 2'd0,
    RESP    = 2'd1,
    ADVANCE = 2'd2,
    IDLE    = 2'd3
  } state_t;

endpackage

// File: rtl/food_placer.sv
// food_placer: consumes candidate coordinates from the food generator,
// looks each one up in the snake-body occupancy map and commits the first
// free one as the food position. When the head lands on the food it pulses
// grow, bumps a saturating score and starts the next placement.
//
// Ports
//   clk_out             system clock, rising edge
//   rst_n               asynchronous active-low reset
//   head_x/head_y       snake head position, qualified by head_valid pulse
//   cand_x/cand_y       generator candidate, advanced by an eaten pulse
//   eaten               one-cycle advance request to the generator
//   occ_rd_en/x/y       occupancy map read strobe and address
//   occ_rd_data         occupancy answer, sampled the cycle after the strobe
//   food_x/food_y       committed food position, food_valid qualifies it
//   grow                one-cycle pulse when the snake eats
//   score               foods eaten, saturating
//   board_full          sticky: a candidate was forced onto an occupied cell
module food_placer
  import food_placer_pkg::*;
#(
  parameter int COORD_W   = food_placer_pkg::COORD_W,
  parameter int MAX_RETRY = 9,
  parameter int SCORE_W   = food_placer_pkg::SCORE_W
) (
  input  logic               clk_out,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic               head_valid,
  input  logic [COORD_W-1:0] cand_x,
  input  logic [COORD_W-1:0] cand_y,
  output logic               eaten,
  output logic               occ_rd_en,
  output logic [COORD_W-1:0] occ_rd_x,
  output logic [COORD_W-1:0] occ_rd_y,
  input  logic               occ_rd_data,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               grow,
  output logic [SCORE_W-1:0] score,
  output logic               board_full
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [RETRY_W-1:0]   retry_r;
  logic [RETRY_W-1:0]   retry_nxt_s;
  logic                 eaten_nxt_s;
  logic                 rd_en_nxt_s;
  logic [COORD_W-1:0]   rd_x_nxt_s;
  logic [COORD_W-1:0]   rd_y_nxt_s;
  logic [COORD_W-1:0]   food_x_nxt_s;
  logic [COORD_W-1:0]   food_y_nxt_s;
  logic                 food_valid_nxt_s;
  logic                 grow_nxt_s;
  logic [SCORE_W-1:0]   score_nxt_s;
  logic                 board_full_nxt_s;
  logic                 hit_s;
  logic                 commit_s;

  assign hit_s = head_valid && (head_x == food_x) && (head_y == food_y);

  // Commit on a free cell, or unconditionally once the retry budget is spent.
  assign commit_s = !occ_rd_data || (retry_r == RETRY_W'(MAX_RETRY));

  // Next-state and next-output logic for the placement FSM.
  always_comb begin
    state_nxt_s      = state_r;
    retry_nxt_s      = retry_r;
    eaten_nxt_s      = 1'b0;
    rd_en_nxt_s      = 1'b0;
    rd_x_nxt_s       = occ_rd_x;
    rd_y_nxt_s       = occ_rd_y;
    food_x_nxt_s     = food_x;
    food_y_nxt_s     = food_y;
    food_valid_nxt_s = food_valid;
    grow_nxt_s       = 1'b0;
    score_nxt_s      = score;
    board_full_nxt_s = board_full;
    case (state_r)
      CHECK: begin
        // The read address register doubles as the held candidate: it is
        // only rewritten in the next CHECK, after this candidate resolves.
        rd_en_nxt_s = 1'b1;
        rd_x_nxt_s  = cand_x;
        rd_y_nxt_s  = cand_y;
        state_nxt_s = RESP;
      end
      RESP: begin
        if (commit_s) begin
          food_x_nxt_s     = occ_rd_x;
          food_y_nxt_s     = occ_rd_y;
          food_valid_nxt_s = 1'b1;
          board_full_nxt_s = board_full | occ_rd_data;
          retry_nxt_s      = '0;
          state_nxt_s      = IDLE;
        end else begin
          retry_nxt_s = retry_r + RETRY_W'(1);
          eaten_nxt_s = 1'b1;
          state_nxt_s = ADVANCE;
        end
      end
      ADVANCE: begin
        // eaten is high during this cycle; the generator advances on the
        // edge that leaves it, so CHECK sees the new candidate.
        state_nxt_s = CHECK;
      end
      IDLE: begin
        if (hit_s) begin
          grow_nxt_s       = 1'b1;
          score_nxt_s      = (score == {SCORE_W{1'b1}}) ? score : score + SCORE_W'(1);
          food_valid_nxt_s = 1'b0;
          eaten_nxt_s      = 1'b1;
          state_nxt_s      = ADVANCE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = CHECK;
      end
    endcase
  end

  // State, retry counter and all registered outputs.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= CHECK;
      retry_r    <= '0;
      eaten      <= 1'b0;
      occ_rd_en  <= 1'b0;
      occ_rd_x   <= '0;
      occ_rd_y   <= '0;
      food_x     <= '0;
      food_y     <= '0;
      food_valid <= 1'b0;
      grow       <= 1'b0;
      score      <= '0;
      board_full <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      retry_r    <= retry_nxt_s;
      eaten      <= eaten_nxt_s;
      occ_rd_en  <= rd_en_nxt_s;
      occ_rd_x   <= rd_x_nxt_s;
      occ_rd_y   <= rd_y_nxt_s;
      food_x     <= food_x_nxt_s;
      food_y     <= food_y_nxt_s;
      food_valid <= food_valid_nxt_s;
      grow       <= grow_nxt_s;
      score      <= score_nxt_s;
      board_full <= board_full_nxt_s;
    end
  end

endmodule
